interp_linear: RTL and testbench
================================

Name: interp_linear

Overview:
Linear interpolator that sits directly upstream of the delta-sigma modulator top.
- Accepts signed 14-bit samples at the low (data) rate through a valid/ready handshake into a small FIFO.
- Produces one interpolated 14-bit sample per fast clock, RATIO = 2^LOG2_RATIO clocks per input sample.
- Its vout drives the modulator's vin directly, replacing file-level upsampling with in-fabric interpolation on the modulator clock.

Parameters:
WIDTH 14 sample width, signed two's complement (input and output)
LOG2_RATIO 4 log2 of interpolation ratio (RATIO = 16 output clocks per input sample)
LOG2_DEPTH 2 log2 of input FIFO depth (DEPTH = 4 entries)

Ports:
clock in 1 fast (modulator) clock; all logic on posedge
reset in 1 synchronous, active-high; clears all state
din in WIDTH signed input sample
din_valid in 1 input sample valid
din_ready out 1 FIFO can accept; push occurs when din_valid && din_ready
vout out WIDTH signed interpolated sample, registered, to modulator vin
underrun out 1 sticky flag: FIFO empty at a segment boundary

Behaviour:
- Reset (sync, active-high, any cycle including mid-RUN): vout=0, underrun=0, FIFO count=0, din_ready=1, state=IDLE, prev=curr=0, acc=0, phase=0. Takes effect on the next posedge; a push in the reset cycle is discarded.
- FIFO:
  - din_ready = (count != DEPTH), from the registered count only. No combinational path from pop to din_ready.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a sample pushed in cycle t is poppable no earlier than t+1.
- Internal registers:
  - prev, curr: WIDTH signed.
  - delta = curr - prev: WIDTH+1 signed, combinational.
  - acc: WIDTH+LOG2_RATIO signed.
  - phase: LOG2_RATIO-bit counter, wraps RATIO-1 -> 0.
- State IDLE:
  - vout held 0.
  - When count>0: pop s; prev<=0, curr<=s, acc<=0, phase<=0; go RUN.
- State RUN, every cycle:
  - vout <= acc >>> LOG2_RATIO (arithmetic shift, i.e. floor division).
  - phase <= phase+1.
  - If phase != RATIO-1: acc <= acc + delta (sign-extended).
  - If phase == RATIO-1 (segment boundary), acc <= curr << LOG2_RATIO, and:
    - count>0: pop s; prev<=curr, curr<=s.
    - count==0: prev<=curr, curr<=curr (hold; delta becomes 0); underrun<=1.
  - RUN never returns to IDLE except via reset.
- Output sequence: within a segment, vout on the cycle after phase j equals floor((prev*RATIO + j*delta)/RATIO), j=0..RATIO-1.
  - The first RUN output is 0 (prev=0); vout reaches the first sample at the start of the second segment.
- Latency: a sample popped at a boundary appears exactly (unramped) on vout RATIO+1 clocks later.
- Width: acc stays between prev*RATIO and curr*RATIO, so no overflow or saturation is possible at full scale (-8192..8191).
- underrun is cleared only by reset. Resumed input after an underrun continues interpolation normally from the held value.

Test Plan:
- Reset: assert reset 3 cycles -> vout=0, din_ready=1, underrun=0. Release, no input -> vout stays 0 indefinitely, underrun stays 0 (IDLE).
- Ramp: push 1600, then keep FIFO fed with 1600 -> vout = 0, 100, 200, ..., 1500 over the first 16 RUN outputs, then constant 1600. underrun=0.
- Rounding: push -1, keep fed with -1 -> first segment vout = 0, -1, -1, ..., -1 (floor: -1/16 -> -1). Push 8191 then -8192 -> second segment starts at 8191, last value of that segment = -7169, no wrap.
- Backpressure: hold din_valid=1 with samples 1..8 from reset -> 5 accepted (1 popped in IDLE + 4 buffered), then din_ready=0. Exactly one more accepted per 16-clock boundary pop. Outputs follow 1,2,3,... in order.
- Underrun: feed 10 then stop -> after FIFO drains, vout holds at last sample with delta=0. underrun rises the cycle after the empty boundary and stays 1 after feeding resumes (push 50 -> ramp toward 50).
- Mid-operation reset: reset mid-segment with 3 entries buffered -> next cycle vout=0, count=0, din_ready=1, underrun=0. Buffered samples are lost; the next push restarts from IDLE.

Source files
------------

// File: rtl/interp_linear.sv
// Linear interpolator feeding the delta-sigma modulator: buffers low-rate samples
// in a small FIFO and ramps between consecutive samples over RATIO fast clocks.
module interp_linear #(
    parameter int WIDTH      = 14,
    parameter int LOG2_RATIO = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] vout,
    output logic             underrun
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = WIDTH + LOG2_RATIO;
    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]        fifo_mem [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LOG2_DEPTH:0]     count_reg;
    logic                    push, pop, boundary;
    logic [WIDTH-1:0]        head;

    logic signed [WIDTH-1:0]  prev_reg, curr_reg;
    logic signed [WIDTH:0]    delta;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [LOG2_RATIO-1:0]    phase_reg;
    logic [WIDTH-1:0]         vout_reg;
    logic                     underrun_reg;

    // Ready depends only on the registered count, never on this cycle's pop.
    assign din_ready = (count_reg != FULL_COUNT);
    assign push      = din_valid && din_ready;
    assign head      = fifo_mem[rd_ptr_reg];
    assign boundary  = &phase_reg;
    assign delta     = (WIDTH + 1)'(curr_reg) - (WIDTH + 1)'(prev_reg);
    assign vout      = vout_reg;
    assign underrun  = underrun_reg;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (boundary && (count_reg != '0)) begin
                    pop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_reg     <= '0;
            curr_reg     <= '0;
            acc_reg      <= '0;
            phase_reg    <= '0;
            vout_reg     <= '0;
            underrun_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            vout_reg <= '0;
            if (pop) begin
                prev_reg  <= '0;
                curr_reg  <= head;
                acc_reg   <= '0;
                phase_reg <= '0;
            end
        end else begin
            // Top WIDTH bits of acc are the floor of acc / RATIO.
            vout_reg  <= acc_reg[ACC_W-1:LOG2_RATIO];
            phase_reg <= phase_reg + 1'b1;
            if (!boundary) begin
                acc_reg <= acc_reg + ACC_W'(delta);
            end else begin
                acc_reg  <= {curr_reg, {LOG2_RATIO{1'b0}}};
                prev_reg <= curr_reg;
                if (pop) begin
                    curr_reg <= head;
                end else begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_interp_linear.sv
// Self-checking bench for interp_linear: directed scenarios plus random traffic,
// compared every cycle against a segment-level interpolation model.
module tb_interp_linear;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic signed [13:0] vout;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model state: sample queue, current segment endpoints and position.
    int  m_q[$];
    bit  m_run;
    int  m_prev, m_curr, m_j;
    bit  m_under;
    int  m_vout;
    bit  last_acc;

    interp_linear dut (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .vout     (vout),
        .underrun (underrun)
    );

    always #5 clock = ~clock;

    function automatic int floor_div16(input int a);
        int q;
        q = a / 16;
        if ((a % 16 != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic step(input bit rst, input bit v, input int d);
        int s;
        reset     = rst;
        din_valid = v;
        din       = 14'(d);
        last_acc  = 1'b0;
        if (rst) begin
            m_q.delete();
            m_run = 0; m_prev = 0; m_curr = 0; m_j = 0; m_under = 0; m_vout = 0;
        end else begin
            last_acc = v && (m_q.size() != 4);
            if (!m_run) begin
                m_vout = 0;
                if (m_q.size() > 0) begin
                    s = m_q.pop_front();
                    m_prev = 0; m_curr = s; m_j = 0; m_run = 1;
                end
            end else begin
                m_vout = floor_div16(m_prev * 16 + m_j * (m_curr - m_prev));
                if (m_j == 15) begin
                    m_prev = m_curr;
                    if (m_q.size() > 0) m_curr = m_q.pop_front();
                    else m_under = 1;
                end
                m_j = (m_j + 1) % 16;
            end
            if (last_acc) begin
                m_q.push_back(d);
                $display("push %0d at cycle %0d", d, cycle);
            end
        end
        @(posedge clock);
        #1;
        cycle++;
        checks++;
        assert (int'(vout) === m_vout) else begin
            errors++;
            $error("FAIL vout cycle %0d: got %0d expected %0d", cycle, int'(vout), m_vout);
        end
        checks++;
        assert (din_ready === (m_q.size() != 4)) else begin
            errors++;
            $error("FAIL din_ready cycle %0d: got %0b expected %0b", cycle, din_ready, (m_q.size() != 4));
        end
        checks++;
        assert (underrun === m_under) else begin
            errors++;
            $error("FAIL underrun cycle %0d: got %0b expected %0b", cycle, underrun, m_under);
        end
    endtask

    initial begin
        int nxt;
        #1;
        // Reset and idle.
        repeat (3) step(1, 0, 0);
        repeat (20) step(0, 0, 0);

        // Ramp 0 -> 1600 in steps of 100, then flat.
        repeat (48) step(0, 1, 1600);

        // Floor rounding of negative values.
        step(1, 0, 0);
        repeat (40) step(0, 1, -1);

        // Full-scale swing without wrap.
        step(1, 0, 0);
        step(0, 1, 8191);
        step(0, 1, -8192);
        repeat (50) step(0, 1, -8192);

        // Backpressure with incrementing samples.
        step(1, 0, 0);
        nxt = 1;
        repeat (6) begin
            step(0, 1, nxt);
            if (last_acc) nxt++;
        end
        checks++;
        assert (din_ready === 1'b0) else begin
            errors++;
            $error("FAIL bp_full: got din_ready=%0b expected 0", din_ready);
        end
        repeat (80) begin
            step(0, 1, nxt);
            if (last_acc) nxt++;
        end

        // Underrun and recovery.
        step(1, 0, 0);
        step(0, 1, 10);
        repeat (60) step(0, 0, 0);
        step(0, 1, 50);
        repeat (40) step(0, 0, 0);

        // Mid-operation reset with entries buffered; push in reset cycle is lost.
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 100 * (i + 1));
        repeat (5) step(0, 0, 0);
        step(1, 1, 999);
        repeat (3) step(0, 0, 0);
        step(0, 1, 77);
        repeat (40) step(0, 0, 0);

        // Random traffic with occasional resets.
        step(1, 0, 0);
        repeat (600) begin
            step($urandom_range(0, 249) == 0,
                 $urandom_range(0, 99) < 25,
                 int'($urandom_range(0, 16383)) - 8192);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
